// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants and the common-data-bus broadcast bundle.
//   DATA_W, TAG_W : default CDB data / tag widths
//   SRC_W         : width of the winning-unit index (up to 8 units)
//   TAG_NULL      : tag value meaning "no producer"; such requests are ignored
//   cdb_bcast_t   : one broadcast beat (valid, data, tag, src) at default widths
package cdb_pkg;
    localparam int DATA_W   = 16;
    localparam int TAG_W    = 3;
    localparam int SRC_W    = 3;
    localparam int TAG_NULL = 0;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [SRC_W-1:0]  src;
    } cdb_bcast_t;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational rotating-priority picker.
//   req     : eligible request vector
//   ptr     : index of the previous winner; search begins at ptr+1 mod N_REQ
//   grant   : one-hot winner (zero if no request)
//   win_idx : binary index of the winner
//   valid   : a winner exists
module rr_picker
    import cdb_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [SRC_W-1:0] win_idx,
    output logic             valid
);

    // Walk the candidates in rotation order; loop bounds are constant so the
    // nested compare unrolls into a plain priority mux.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        valid   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!valid && req[i] && ((int'(ptr) + k) % N_REQ == i)) begin
                    grant[i] = 1'b1;
                    win_idx  = SRC_W'(i);
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the common data bus to one finished functional unit per
// cycle and broadcasts the winner's result/tag one cycle later.
//   Clock, Reset (async, active-high), Clear (sync flush)
//   Req[N_REQ]            : unit i has a finished result
//   Data_in, Tag_in       : per-unit result and producing-station tag (slice i)
//   Grant[N_REQ]          : combinational one-hot grant (or zero)
//   CDB_Valid/Data/Tag/Src: registered broadcast; fields hold while not valid
// Build option: define CDB_ARB_ROUND_ROBIN_EN for round-robin selection;
// otherwise the lowest eligible index always wins.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = cdb_pkg::DATA_W,
    parameter int TAG_W  = cdb_pkg::TAG_W
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Clear,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*DATA_W-1:0] Data_in,
    input  logic [N_REQ*TAG_W-1:0]  Tag_in,
    output logic [N_REQ-1:0]        Grant,
    output logic                    CDB_Valid,
    output logic [DATA_W-1:0]       CDB_Data,
    output logic [TAG_W-1:0]        CDB_Tag,
    output logic [SRC_W-1:0]        CDB_Src
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [SRC_W-1:0]  src;
    } bcast_t;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  win_grant;
    logic [SRC_W-1:0]  win_idx;
    logic              win_vld;
    logic [SRC_W-1:0]  last_ptr;
    logic [DATA_W-1:0] win_data;
    logic [TAG_W-1:0]  win_tag;
    bcast_t            bcast;

    // A result carrying the null tag has no consumer and is never granted.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++)
            eligible[i] = Req[i] && (Tag_in[i*TAG_W +: TAG_W] != TAG_W'(TAG_NULL));
    end

    // Reset and Clear suppress arbitration in the same cycle.
    assign pick_req = (Reset || Clear) ? '0 : eligible;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (pick_req),
        .ptr     (last_ptr),
        .grant   (win_grant),
        .win_idx (win_idx),
        .valid   (win_vld)
    );

    assign Grant = win_grant;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    // Starts at N_REQ-1 so unit 0 is first in line after reset; Clear keeps it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            last_ptr <= SRC_W'(N_REQ - 1);
        else if (win_vld)
            last_ptr <= win_idx;
    end
`else
    // Pinned pointer: the search always starts at index 0 (fixed priority).
    assign last_ptr = SRC_W'(N_REQ - 1);
`endif

    // One-hot AND-OR mux of the winner's payload.
    always_comb begin
        win_data = '0;
        win_tag  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_grant[i]) begin
                win_data = win_data | Data_in[i*DATA_W +: DATA_W];
                win_tag  = win_tag  | Tag_in[i*TAG_W +: TAG_W];
            end
        end
    end

    // Payload only loads on a grant, so it holds while valid is low.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bcast <= '0;
        end else begin
            bcast.valid <= win_vld;
            if (win_vld) begin
                bcast.data <= win_data;
                bcast.tag  <= win_tag;
                bcast.src  <= win_idx;
            end
        end
    end

    assign CDB_Valid = bcast.valid;
    assign CDB_Data  = bcast.data;
    assign CDB_Tag   = bcast.tag;
    assign CDB_Src   = bcast.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed + randomized scoreboard bench for cdb_arbiter.
// Grants are checked against a queue-based selection model when issued; each
// grant pushes an expected broadcast that an independent monitor pops when
// the bus shows one.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int TW = 3;

    logic            Clock = 1'b0;
    logic            Reset;
    logic            Clear;
    logic [N-1:0]    Req;
    logic [N*DW-1:0] Data_in;
    logic [N*TW-1:0] Tag_in;
    logic [N-1:0]    Grant;
    logic            CDB_Valid;
    logic [DW-1:0]   CDB_Data;
    logic [TW-1:0]   CDB_Tag;
    logic [2:0]      CDB_Src;

    cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Clear     (Clear),
        .Req       (Req),
        .Data_in   (Data_in),
        .Tag_in    (Tag_in),
        .Grant     (Grant),
        .CDB_Valid (CDB_Valid),
        .CDB_Data  (CDB_Data),
        .CDB_Tag   (CDB_Tag),
        .CDB_Src   (CDB_Src)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        cdb_bcast_t b;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

`ifdef CDB_ARB_ROUND_ROBIN_EN
    int m_last = N - 1;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Winner per the selection rules: walk units in search order, first one
    // with a request and a non-null tag wins; -1 means no grant.
    function automatic int model_pick(input logic [N-1:0] r, input logic [N*TW-1:0] t);
        int order[$];
        int start;
`ifdef CDB_ARB_ROUND_ROBIN_EN
        start = (m_last + 1) % N;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) order.push_back((start + k) % N);
        foreach (order[j]) begin
            if (((r >> order[j]) & 1) != 0 && (TW'(t >> (order[j] * TW))) != 0)
                return order[j];
        end
        return -1;
    endfunction

    // One arbitration cycle: drive after the edge, check Grant mid-cycle.
    task automatic step(input logic [N-1:0] r, input logic [N*TW-1:0] t,
                        input logic [N*DW-1:0] d, input logic clr, output logic [N-1:0] g);
        int   w;
        exp_t e;
        @(posedge Clock);
        #1;
        Req = r; Tag_in = t; Data_in = d; Clear = clr;
        @(negedge Clock);
        w = clr ? -1 : model_pick(r, t);
        check("grant", 64'(Grant), (w < 0) ? 64'd0 : 64'(1) << w);
        g = Grant;
        if (w >= 0) begin
            e.b.valid = 1'b1;
            e.b.data  = DW'(d >> (w * DW));
            e.b.tag   = TW'(t >> (w * TW));
            e.b.src   = 3'(w);
            e.cyc     = cyc;
            sbq.push_back(e);
`ifdef CDB_ARB_ROUND_ROBIN_EN
            m_last = w;
`endif
        end
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input bit live);
        @(posedge Clock);
        #1;
        if (live) check("pre_reset_valid", 64'(CDB_Valid), 64'd1);
        #1;
        Reset = 1'b1;
        Req   = '0;
        sbq.delete();
`ifdef CDB_ARB_ROUND_ROBIN_EN
        m_last = N - 1;
`endif
        #1;
        check("rst_valid", 64'(CDB_Valid), 64'd0);
        check("rst_data", 64'(CDB_Data), 64'd0);
        check("rst_tag", 64'(CDB_Tag), 64'd0);
        check("rst_src", 64'(CDB_Src), 64'd0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // Monitor: pops the broadcast expected from last cycle's grant; otherwise
    // the bus must be idle with payload held.
    initial begin
        cdb_bcast_t held;
        exp_t       e;
        held = '0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                check("mon_rst_valid", 64'(CDB_Valid), 64'd0);
                check("mon_rst_data", 64'(CDB_Data), 64'd0);
                held = '0;
            end else if (sbq.size() > 0 && sbq[0].cyc == cyc - 1) begin
                e = sbq.pop_front();
                check("cdb_valid", 64'(CDB_Valid), 64'd1);
                check("cdb_data", 64'(CDB_Data), 64'(e.b.data));
                check("cdb_tag", 64'(CDB_Tag), 64'(e.b.tag));
                check("cdb_src", 64'(CDB_Src), 64'(e.b.src));
                held = e.b;
            end else begin
                check("cdb_idle", 64'(CDB_Valid), 64'd0);
                check("hold_data", 64'(CDB_Data), 64'(held.data));
                check("hold_tag", 64'(CDB_Tag), 64'(held.tag));
                check("hold_src", 64'(CDB_Src), 64'(held.src));
            end
        end
    end

    initial begin
        logic [N-1:0]    g;
        logic [N-1:0]    r;
        logic [N*TW-1:0] t;
        logic [N*DW-1:0] d;
        logic [N-1:0]    seq[6];
        logic            clr;

        Reset = 1'b1; Clear = 1'b0; Req = '0; Data_in = '0; Tag_in = '0;
        #1;
        check("init_valid", 64'(CDB_Valid), 64'd0);
        check("init_data", 64'(CDB_Data), 64'd0);
        check("init_src", 64'(CDB_Src), 64'd0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;

        // All three requesting, tags 1,2,3.
`ifdef CDB_ARB_ROUND_ROBIN_EN
        seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        for (int i = 0; i < 6; i++) begin
            step(3'b111, {3'd3, 3'd2, 3'd1}, {16'h3333, 16'h2222, 16'h1111}, 1'b0, g);
            check("seq_grant", 64'(g), 64'(seq[i]));
        end
        step(3'b000, '0, '0, 1'b0, g);

        // Single-cycle request from unit 1.
        step(3'b010, {3'd0, 3'd4, 3'd0}, {16'h0, 16'h00A5, 16'h0}, 1'b0, g);
        check("single_grant", 64'(g), 64'b010);
        step(3'b000, '0, '0, 1'b0, g);
        check("single_valid", 64'(CDB_Valid), 64'd1);
        check("single_data", 64'(CDB_Data), 64'h00A5);
        check("single_tag", 64'(CDB_Tag), 64'd4);
        check("single_src", 64'(CDB_Src), 64'd1);
        step(3'b000, '0, '0, 1'b0, g);

        // Clear suppresses the grant; pointer retained, unit 0 next.
        do_reset(1'b0);
        step(3'b101, {3'd6, 3'd0, 3'd5}, {16'hC0DE, 16'h0, 16'hBEEF}, 1'b1, g);
        check("clear_grant", 64'(g), 64'd0);
        step(3'b101, {3'd6, 3'd0, 3'd5}, {16'hC0DE, 16'h0, 16'hBEEF}, 1'b0, g);
        check("post_clear_grant", 64'(g), 64'b001);
        step(3'b000, '0, '0, 1'b0, g);

        // Reset right after a grant drops the pending broadcast.
        step(3'b001, {3'd0, 3'd0, 3'd7}, {16'h0, 16'h0, 16'h5A5A}, 1'b0, g);
        do_reset(1'b1);
        step(3'b100, {3'd2, 3'd0, 3'd0}, {16'h7777, 16'h0, 16'h0}, 1'b0, g);
        check("post_rst_grant", 64'(g), 64'b100);
        step(3'b000, '0, '0, 1'b0, g);

        // Null tag on unit 0: only unit 1 may win.
        for (int i = 0; i < 4; i++) begin
            step(3'b011, {3'd0, 3'd5, 3'd0}, {16'h0, 16'h1234, 16'hDEAD}, 1'b0, g);
            check("null_tag_grant", 64'(g), 64'b010);
        end
        step(3'b000, '0, '0, 1'b0, g);

        // Randomized traffic obeying the handshake: ungranted units hold.
        r = '0; t = '0; d = '0; g = '0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N; i++) begin
                if (g[i] || !r[i] || t[i*TW +: TW] == 0) begin
                    r[i]            = ($urandom_range(0, 3) != 0);
                    t[i*TW +: TW]   = 3'($urandom_range(0, 7));
                    d[i*DW +: DW]   = 16'($urandom);
                end
            end
            clr = ($urandom_range(0, 15) == 0);
            step(r, t, d, clr, g);
        end

        repeat (3) step(3'b000, '0, '0, 1'b0, g);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
